// File: rtl/dmni_mem_arbiter_pkg.sv
// rtl/dmni_mem_arbiter_pkg.sv - shared types and requester indices for the DMNI memory arbiter
package dmni_mem_arbiter_pkg;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  localparam int MEM_REQ_SEND  = 0;
  localparam int MEM_REQ_RECV  = 1;
  localparam int MEM_REQ_BRMON = 2;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmni_mem_arbiter_rr_arbiter.sv
// rtl/dmni_mem_arbiter_rr_arbiter.sv - combinational rotate-priority pick starting at rr_ptr
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    winner,
  output logic             any_req
);

  localparam int SW = IW + 1;

  logic [2*N_REQ-1:0] dbl;
  logic [SW-1:0]      sum;
  logic               found;

  // Rotating the doubled vector puts requester rr_ptr at bit 0.
  always_comb begin
    dbl    = {req, req} >> rr_ptr;
    winner = '0;
    sum    = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + SW'(k);
        if (sum >= SW'(N_REQ)) begin
          sum = sum - SW'(N_REQ);
        end
        winner = sum[IW-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/dmni_mem_arbiter.sv
// rtl/dmni_mem_arbiter.sv - round-robin, burst-locked sharing of the DMNI local-memory port
module dmni_mem_arbiter
  import dmni_mem_arbiter_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       last_i,
  input  logic [N_REQ-1:0][3:0]  we_i,
  input  logic [N_REQ-1:0][31:0] addr_i,
  input  logic [N_REQ-1:0][31:0] wdata_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   busy_o,
  output logic [3:0]             mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [31:0]            mem_data_o,
  input  logic [31:0]            mem_data_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
  logic [N_REQ-1:0] gnt_nxt, rvalid_nxt;
  logic [31:0]     rdata_nxt;

  logic [IW-1:0]   winner;
  logic            any_req;
  logic            owner_req;
  logic            beat;
  logic            cnt_hit;
  mem_req_t        sel_req;
  mem_req_t        mem_req;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_arbiter (
    .req     (req_i),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_req = req_i[owner];
  assign beat      = (state == ARB_GRANT) && owner_req;
  assign cnt_hit   = (beat_cnt + CW'(1)) == CW'(MAX_BURST);
  assign sel_req   = '{we: we_i[owner], addr: addr_i[owner], data: wdata_i[owner]};
  assign mem_req   = beat ? sel_req : '0;

  assign mem_we_o   = mem_req.we;
  assign mem_addr_o = mem_req.addr;
  assign mem_data_o = mem_req.data;
  assign busy_o     = (state == ARB_GRANT);

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    gnt_nxt      = gnt_o;
    rvalid_nxt   = '0;
    rdata_nxt    = rdata_o;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          owner_nxt        = winner;
          gnt_nxt          = '0;
          gnt_nxt[winner]  = 1'b1;
          beat_cnt_nxt     = '0;
          state_nxt        = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (beat) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
          if (sel_req.we == 4'h0) begin
            rvalid_nxt[owner] = 1'b1;
            rdata_nxt         = mem_data_i;
          end
        end
        // A dropped request releases too, so an idle owner cannot starve others.
        if (!owner_req || last_i[owner] || cnt_hit) begin
          state_nxt  = ARB_IDLE;
          gnt_nxt    = '0;
          rr_ptr_nxt = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ARB_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      gnt_o    <= '0;
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      gnt_o    <= gnt_nxt;
      rvalid_o <= rvalid_nxt;
      rdata_o  <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// tb/tb_dmni_mem_arbiter.sv - scoreboard bench for dmni_mem_arbiter
module tb_dmni_mem_arbiter;

  logic            clk;
  logic            rst_i;
  logic [2:0]      req_i;
  logic [2:0]      last_i;
  logic [2:0][3:0] we_i;
  logic [2:0][31:0] addr_i;
  logic [2:0][31:0] wdata_i;
  logic [2:0]      gnt_o;
  logic [2:0]      rvalid_o;
  logic [31:0]     rdata_o;
  logic            busy_o;
  logic [3:0]      mem_we_o;
  logic [31:0]     mem_addr_o;
  logic [31:0]     mem_data_o;
  logic [31:0]     mem_data_i;

  typedef struct {
    int          idx;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } rd_t;

  beat_t exp_beat[$];
  rd_t   exp_rd[$];
  int    vectors = 0;
  int    miscompares = 0;
  logic  mon_en = 1'b0;

  dmni_mem_arbiter #(
    .N_REQ     (3),
    .MAX_BURST (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .last_i     (last_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .busy_o     (busy_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i)
  );

  // Memory model: data for the presented address is ready by the next edge.
  assign mem_data_i = {16'hA5A5, mem_addr_o[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_one(input int idx, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
    beat_t e;
    e.idx = idx; e.we = wen; e.addr = a; e.data = d;
    exp_beat.push_back(e);
    if (wen == 4'h0) begin
      rd_t r;
      r.idx  = idx;
      r.data = {16'hA5A5, a[15:0]};
      exp_rd.push_back(r);
    end
  endtask

  task automatic push_burst(input int idx, input int first, input int n, input logic [31:0] base, input logic [3:0] wen);
    for (int b = first; b < first + n; b++) begin
      logic [31:0] a;
      a = base + 32'(4 * b);
      push_one(idx, wen, a, {8'(idx), 8'hD0, a[15:0]});
    end
  endtask

  // Master: holds each beat until it sees its grant, then advances.
  task automatic master(input int idx, input int nbeats, input logic [31:0] base, input logic [3:0] wen, input bit use_last);
    int b = 0;
    int guard = 0;
    logic [31:0] a;
    while (b < nbeats && guard < 400) begin
      a = base + 32'(4 * b);
      req_i[idx]   = 1'b1;
      addr_i[idx]  = a;
      we_i[idx]    = wen;
      wdata_i[idx] = {8'(idx), 8'hD0, a[15:0]};
      last_i[idx]  = use_last && (b == nbeats - 1);
      @(negedge clk);
      if (gnt_o[idx]) b++;
      @(posedge clk);
      #1;
      guard++;
    end
    req_i[idx]   = 1'b0;
    last_i[idx]  = 1'b0;
    we_i[idx]    = 4'h0;
    addr_i[idx]  = 32'h0;
    wdata_i[idx] = 32'h0;
    chk($sformatf("master%0d_done", idx), 32'(b), 32'(nbeats));
  endtask

  // Monitor: compares every accepted beat and every read return against the queues.
  initial begin
    int prev;
    int cur;
    logic [2:0] acc;
    beat_t e;
    rd_t r;
    prev = -1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        acc = req_i & gnt_o;
        if (acc != 3'b000) begin
          cur = 0;
          for (int i = 0; i < 3; i++) if (acc[i]) cur = i;
          if (prev >= 0) chk("no_bubble_owner", 32'(cur), 32'(prev));
          prev = cur;
          chk("beat_expected", 32'(exp_beat.size() != 0), 32'd1);
          if (exp_beat.size() != 0) begin
            e = exp_beat.pop_front();
            chk("beat_gnt", 32'(gnt_o), 32'(1) << e.idx);
            chk("beat_we", 32'(mem_we_o), 32'(e.we));
            chk("beat_addr", mem_addr_o, e.addr);
            chk("beat_data", mem_data_o, e.data);
          end
        end else begin
          prev = -1;
          chk("idle_mem_zero", 32'(|{mem_we_o, mem_addr_o, mem_data_o}), 32'd0);
        end
        if (rvalid_o != 3'b000) begin
          chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
          if (exp_rd.size() != 0) begin
            r = exp_rd.pop_front();
            chk("rvalid_onehot", 32'(rvalid_o), 32'(1) << r.idx);
            chk("rdata", rdata_o, r.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    req_i   = 3'b111;
    last_i  = 3'b000;
    we_i    = '0;
    addr_i  = '0;
    wdata_i = '0;

    // Reset state while all requesters are asking.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    we_i   = {4'hF, 4'hF, 4'hF};
    addr_i = {32'h30, 32'h20, 32'h10};
    rst_i  = 1'b0;
    @(negedge clk);
    chk("t1_pre_busy", 32'(busy_o), 32'd1);
    chk("t1_pre_gnt", 32'(gnt_o), 32'b001);
    chk("t1_pre_addr", mem_addr_o, 32'h10);
    #2 rst_i = 1'b1;
    #1;
    chk("t1_gnt", 32'(gnt_o), 32'd0);
    chk("t1_mem_we", 32'(mem_we_o), 32'd0);
    chk("t1_mem_addr", mem_addr_o, 32'd0);
    chk("t1_busy", 32'(busy_o), 32'd0);
    req_i  = 3'b000;
    we_i   = '0;
    addr_i = '0;
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single write burst from requester 1.
    push_one(1, 4'hF, 32'h100, 32'h01D0_0100);
    push_one(1, 4'hF, 32'h104, 32'h01D0_0104);
    push_one(1, 4'hF, 32'h108, 32'h01D0_0108);
    push_one(1, 4'hF, 32'h10C, 32'h01D0_010C);
    fork
      master(1, 4, 32'h100, 4'hF, 1'b1);
    join_none
    @(negedge clk);
    chk("t2_gnt_before", 32'(gnt_o), 32'd0);
    @(negedge clk);
    chk("t2_gnt_after", 32'(gnt_o), 32'b010);
    wait fork;
    chk("t2_rr_ptr", 32'(dut.rr_ptr), 32'd2);
    @(negedge clk);
    chk("t2_released", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;

    // Two-beat read from requester 0; last return lands in IDLE.
    push_one(0, 4'h0, 32'h20, 32'h00D0_0020);
    push_one(0, 4'h0, 32'h24, 32'h00D0_0024);
    master(0, 2, 32'h20, 4'h0, 1'b1);
    @(negedge clk);
    chk("t3_last_busy", 32'(busy_o), 32'd0);
    chk("t3_last_rvalid", 32'(rvalid_o), 32'b001);
    chk("t3_last_rdata", rdata_o, 32'hA5A5_0024);
    @(posedge clk);
    #1;

    // Single beat from requester 2 moves rr_ptr back to 0.
    push_burst(2, 0, 1, 32'h300, 4'hF);
    master(2, 1, 32'h300, 4'hF, 1'b1);
    chk("t4_rr_ptr0", 32'(dut.rr_ptr), 32'd0);

    // Round robin with all three holding requests: 0,1,2,0.
    push_burst(0, 0, 2, 32'h400, 4'h0);
    push_burst(1, 0, 2, 32'h500, 4'hF);
    push_burst(2, 0, 2, 32'h600, 4'hF);
    push_burst(0, 0, 2, 32'h440, 4'h0);
    fork
      begin
        master(0, 2, 32'h400, 4'h0, 1'b1);
        master(0, 2, 32'h440, 4'h0, 1'b1);
      end
      master(1, 2, 32'h500, 4'hF, 1'b1);
      master(2, 2, 32'h600, 4'hF, 1'b1);
    join
    @(posedge clk);
    #1;

    // Forced release after 16 beats; requester 0 cuts in, 2 resumes at beat 17.
    push_burst(2, 0, 16, 32'h800, 4'h3);
    push_burst(0, 0, 2, 32'h900, 4'h0);
    push_burst(2, 16, 4, 32'h800, 4'h3);
    fork
      master(2, 20, 32'h800, 4'h3, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        master(0, 2, 32'h900, 4'h0, 1'b1);
      end
    join
    @(posedge clk);
    #1;

    // Owner drops its request after 3 beats without last.
    push_burst(1, 0, 3, 32'hA00, 4'hF);
    master(1, 3, 32'hA00, 4'hF, 1'b0);
    @(negedge clk);
    chk("t6_gnt_hold", 32'(gnt_o), 32'b010);
    @(negedge clk);
    chk("t6_gnt_release", 32'(gnt_o), 32'd0);
    @(posedge clk);
    #1;
    push_burst(1, 0, 1, 32'hB00, 4'hF);
    fork
      master(1, 1, 32'hB00, 4'hF, 1'b1);
    join_none
    begin
      int g;
      g = 0;
      @(negedge clk);
      while (!gnt_o[1] && g < 50) begin
        @(negedge clk);
        g++;
      end
      chk("t6_regrant", 32'(gnt_o[1]), 32'd1);
      chk("t6_beat_cnt", 32'(dut.beat_cnt), 32'd0);
    end
    wait fork;

    repeat (4) @(negedge clk);
    chk("beats_left", 32'(exp_beat.size()), 32'd0);
    chk("reads_left", 32'(exp_rd.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
